// File: rtl/pipe_rd_arbiter.sv
// pipe_rd_arbiter: merges IFU fetches and LSU loads onto one shared AXI-lite
// read master port (AR/R channels only), one transaction in flight at a time.
// Read data is routed back to whichever master owns the current transaction.
// Optional feature macro RD_ARB_RR_EN: round-robin on a simultaneous request,
// otherwise fixed priority LSU over IFU.
module pipe_rd_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  // IFU read master
  input  logic [ADDR_WIDTH-1:0] ifu_araddr_i,
  input  logic                  ifu_arvalid_i,
  output logic                  ifu_arready_o,
  output logic                  ifu_rvalid_o,
  output logic [DATA_WIDTH-1:0] ifu_rdata_o,
  input  logic                  ifu_rready_i,
  // LSU read master
  input  logic [ADDR_WIDTH-1:0] lsu_araddr_i,
  input  logic                  lsu_arvalid_i,
  output logic                  lsu_arready_o,
  output logic                  lsu_rvalid_o,
  output logic [DATA_WIDTH-1:0] lsu_rdata_o,
  input  logic                  lsu_rready_i,
  // Shared read port towards the bus
  output logic [ADDR_WIDTH-1:0] m_araddr_o,
  output logic                  m_arvalid_o,
  input  logic                  m_arready_i,
  input  logic                  m_rvalid_i,
  input  logic [DATA_WIDTH-1:0] m_rdata_i,
  output logic                  m_rready_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } state_t;

  localparam logic OWNER_IFU = 1'b0;
  localparam logic OWNER_LSU = 1'b1;

  state_t state_q, state_d;
  logic   owner_q, owner_d;
  logic   last_q,  last_d;
  logic   grant;
  logic   owner_arvalid;
  logic   owner_rready;

  // Grant decision for the IDLE cycle: which master wins if any is requesting.
`ifdef RD_ARB_RR_EN
  // On a tie the master that was not served last wins; a lone requester wins.
  assign grant = (ifu_arvalid_i && lsu_arvalid_i) ? ~last_q : lsu_arvalid_i;
`else
  // Fixed priority: LSU wins whenever it requests.
  assign grant = lsu_arvalid_i ? OWNER_LSU : OWNER_IFU;
`endif

  // Owner-selected views of the master-side handshake signals.
  assign owner_arvalid = (owner_q == OWNER_LSU) ? lsu_arvalid_i : ifu_arvalid_i;
  assign owner_rready  = (owner_q == OWNER_LSU) ? lsu_rready_i  : ifu_rready_i;

  // Masters hold AR stable while waiting, so a plain mux suffices for the address.
  assign m_araddr_o = (owner_q == OWNER_LSU) ? lsu_araddr_i : ifu_araddr_i;

  // Read data fans out unmodified; only the owner's rvalid qualifies it.
  assign ifu_rdata_o = m_rdata_i;
  assign lsu_rdata_o = m_rdata_i;

  // State, owner and last-owner registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (rst_i) begin
      state_q <= IDLE;
      owner_q <= OWNER_IFU;
      last_q  <= OWNER_LSU;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
    end
  end

  // Next-state logic and handshake outputs.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    state_d       = state_q;
    owner_d       = owner_q;
    last_d        = last_q;
    m_arvalid_o   = 1'b0;
    m_rready_o    = 1'b0;
    ifu_arready_o = 1'b0;
    lsu_arready_o = 1'b0;
    ifu_rvalid_o  = 1'b0;
    lsu_rvalid_o  = 1'b0;

    case (state_q)
      IDLE: begin
        if (ifu_arvalid_i || lsu_arvalid_i) begin
          owner_d = grant;
          state_d = ADDR;
        end
      end

      ADDR: begin
        // If the owner drops arvalid the request simply stalls here.
        m_arvalid_o   = owner_arvalid;
        ifu_arready_o = (owner_q == OWNER_IFU) && m_arready_i;
        lsu_arready_o = (owner_q == OWNER_LSU) && m_arready_i;
        if (owner_arvalid && m_arready_i) begin
          state_d = DATA;
        end
      end

      DATA: begin
        m_rready_o   = owner_rready;
        ifu_rvalid_o = (owner_q == OWNER_IFU) && m_rvalid_i;
        lsu_rvalid_o = (owner_q == OWNER_LSU) && m_rvalid_i;
        if (m_rvalid_i && owner_rready) begin
          last_d  = owner_q;
          state_d = IDLE;
        end
      end

      // Unused encoding recovers to IDLE with all outputs quiet.
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_pipe_rd_arbiter.sv
// Self-checking bench for pipe_rd_arbiter (default build: fixed priority).
// The bench plays both masters and the shared AXI-lite slave; expected
// transactions are queued in grant order when requests are driven and
// popped when the arbiter presents them on the shared port.
module tb_pipe_rd_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic [AW-1:0] ifu_araddr_i, lsu_araddr_i, m_araddr_o;
  logic          ifu_arvalid_i, ifu_arready_o, ifu_rvalid_o, ifu_rready_i;
  logic          lsu_arvalid_i, lsu_arready_o, lsu_rvalid_o, lsu_rready_i;
  logic [DW-1:0] ifu_rdata_o, lsu_rdata_o, m_rdata_i;
  logic          m_arvalid_o, m_arready_i, m_rvalid_i, m_rready_o;

  typedef struct {
    logic          owner;  // 0 = IFU, 1 = LSU
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } exp_t;

  exp_t sb[$];
  int   n_vec  = 0;
  int   n_fail = 0;
  int   waited;

  pipe_rd_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .ifu_araddr_i  (ifu_araddr_i),
    .ifu_arvalid_i (ifu_arvalid_i),
    .ifu_arready_o (ifu_arready_o),
    .ifu_rvalid_o  (ifu_rvalid_o),
    .ifu_rdata_o   (ifu_rdata_o),
    .ifu_rready_i  (ifu_rready_i),
    .lsu_araddr_i  (lsu_araddr_i),
    .lsu_arvalid_i (lsu_arvalid_i),
    .lsu_arready_o (lsu_arready_o),
    .lsu_rvalid_o  (lsu_rvalid_o),
    .lsu_rdata_o   (lsu_rdata_o),
    .lsu_rready_i  (lsu_rready_i),
    .m_araddr_o    (m_araddr_o),
    .m_arvalid_o   (m_arvalid_o),
    .m_arready_i   (m_arready_i),
    .m_rvalid_i    (m_rvalid_i),
    .m_rdata_i     (m_rdata_i),
    .m_rready_o    (m_rready_o)
  );

  // 10 ns clock
  always #5 clk_i = ~clk_i;

  // Hard stop in case something stalls outside the bounded waits.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge; inputs are driven here.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Act as the shared slave for one transaction: wait (bounded) for the
  // arbiter to present AR, stall AR for ar_stall cycles, then return R data
  // with the owner holding rready low for r_stall cycles.
  task automatic serve(input int ar_stall, input int r_stall, output int n_wait);
    exp_t e;
    n_wait = 0;
    #1;
    while (m_arvalid_o !== 1'b1 && n_wait < 8) begin
      check("idle_quiet", {60'd0, m_rready_o, ifu_rvalid_o, lsu_rvalid_o,
                           ifu_arready_o | lsu_arready_o}, 64'd0);
      tick();
      #1;
      n_wait++;
    end
    check("ar_valid", {63'd0, m_arvalid_o}, 64'd1);
    if (m_arvalid_o !== 1'b1) return;
    if (sb.size() == 0) begin
      check("sb_nonempty", 64'd0, 64'd1);
      return;
    end
    e = sb.pop_front();

    for (int i = 0; i < ar_stall; i++) begin
      check("ar_hold_valid", {63'd0, m_arvalid_o}, 64'd1);
      check("ar_hold_addr", {32'd0, m_araddr_o}, {32'd0, e.addr});
      check("ar_hold_rdy", {62'd0, ifu_arready_o, lsu_arready_o}, 64'd0);
      tick();
      #1;
    end

    m_arready_i = 1'b1;
    #1;
    check("ar_addr", {32'd0, m_araddr_o}, {32'd0, e.addr});
    check("ar_rdy", {62'd0, ifu_arready_o, lsu_arready_o},
          {62'd0, ~e.owner, e.owner});
    tick();
    m_arready_i = 1'b0;
    if (e.owner) lsu_arvalid_i = 1'b0;
    else         ifu_arvalid_i = 1'b0;
    #1;
    check("data_no_ar", {63'd0, m_arvalid_o}, 64'd0);

    m_rvalid_i = 1'b1;
    m_rdata_i  = e.data;
    for (int i = 0; i < r_stall; i++) begin
      #1;
      check("r_hold_rready", {63'd0, m_rready_o}, 64'd0);
      check("r_hold_rvalid", {62'd0, ifu_rvalid_o, lsu_rvalid_o},
            {62'd0, ~e.owner, e.owner});
      check("r_hold_no_ack", {62'd0, ifu_arready_o, lsu_arready_o}, 64'd0);
      tick();
    end

    if (e.owner) lsu_rready_i = 1'b1;
    else         ifu_rready_i = 1'b1;
    #1;
    check("r_rready", {63'd0, m_rready_o}, 64'd1);
    check("r_rvalid", {62'd0, ifu_rvalid_o, lsu_rvalid_o},
          {62'd0, ~e.owner, e.owner});
    check("r_ifu_data", {32'd0, ifu_rdata_o}, {32'd0, e.data});
    check("r_lsu_data", {32'd0, lsu_rdata_o}, {32'd0, e.data});
    tick();
    m_rvalid_i   = 1'b0;
    ifu_rready_i = 1'b0;
    lsu_rready_i = 1'b0;
  endtask

  initial begin
    rst_i         = 1'b1;
    ifu_araddr_i  = '0;
    ifu_arvalid_i = 1'b0;
    ifu_rready_i  = 1'b0;
    lsu_araddr_i  = '0;
    lsu_arvalid_i = 1'b0;
    lsu_rready_i  = 1'b0;
    m_arready_i   = 1'b0;
    m_rvalid_i    = 1'b0;
    m_rdata_i     = '0;

    // Reset state: everything quiet even with requests pending.
    ifu_arvalid_i = 1'b1;
    m_rvalid_i    = 1'b1;
    #2;
    check("reset_quiet", {58'd0, m_arvalid_o, m_rready_o, ifu_arready_o,
                          ifu_rvalid_o, lsu_arready_o, lsu_rvalid_o}, 64'd0);
    repeat (2) tick();
    check("reset_held", {58'd0, m_arvalid_o, m_rready_o, ifu_arready_o,
                         ifu_rvalid_o, lsu_arready_o, lsu_rvalid_o}, 64'd0);
    ifu_arvalid_i = 1'b0;
    m_rvalid_i    = 1'b0;
    rst_i         = 1'b0;
    tick();

    // Reset asserted mid-DATA with R pending.
    ifu_araddr_i  = 32'h2000_0040;
    ifu_arvalid_i = 1'b1;
    tick();                         // now ADDR
    m_arready_i = 1'b1;
    tick();                         // now DATA
    m_arready_i   = 1'b0;
    ifu_arvalid_i = 1'b0;
    m_rvalid_i    = 1'b1;
    m_rdata_i     = 32'h1111_2222;
    #1;
    check("mid_data_rvalid", {62'd0, ifu_rvalid_o, lsu_rvalid_o}, 64'd2);
    rst_i = 1'b1;
    #1;
    check("async_reset_quiet", {58'd0, m_arvalid_o, m_rready_o, ifu_arready_o,
                                ifu_rvalid_o, lsu_arready_o, lsu_rvalid_o}, 64'd0);
    tick();
    rst_i      = 1'b0;
    m_rvalid_i = 1'b0;
    tick();

    // After release: IFU granted one cycle after its request.
    ifu_araddr_i  = 32'h2000_0100;
    ifu_arvalid_i = 1'b1;
    sb.push_back('{owner: 1'b0, addr: 32'h2000_0100, data: 32'hDEAD_BEEF});
    serve(0, 0, waited);
    check("post_reset_latency", 64'(waited), 64'd1);

    // IFU alone, slave ready on the first AR cycle.
    ifu_araddr_i  = 32'h2000_0000;
    ifu_arvalid_i = 1'b1;
    sb.push_back('{owner: 1'b0, addr: 32'h2000_0000, data: 32'h0000_0413});
    serve(0, 0, waited);
    check("ifu_alone_latency", 64'(waited), 64'd1);

    // Tie: LSU served first, IFU granted in the IDLE after LSU's R fire.
    ifu_araddr_i  = 32'h2000_0004;
    ifu_arvalid_i = 1'b1;
    lsu_araddr_i  = 32'h8000_0010;
    lsu_arvalid_i = 1'b1;
    sb.push_back('{owner: 1'b1, addr: 32'h8000_0010, data: 32'hCAFE_0001});
    sb.push_back('{owner: 1'b0, addr: 32'h2000_0004, data: 32'h0000_0093});
    serve(0, 0, waited);
    check("tie_first_latency", 64'(waited), 64'd1);
    serve(0, 0, waited);
    check("tie_second_latency", 64'(waited), 64'd1);

    // IFU owns; LSU arrives mid-transaction and IFU stalls R for 5 cycles.
    ifu_araddr_i  = 32'h2000_0008;
    ifu_arvalid_i = 1'b1;
    sb.push_back('{owner: 1'b0, addr: 32'h2000_0008, data: 32'h0051_8193});
    tick();                         // IDLE sampled IFU alone; now ADDR
    lsu_araddr_i  = 32'h8000_0020;
    lsu_arvalid_i = 1'b1;
    sb.push_back('{owner: 1'b1, addr: 32'h8000_0020, data: 32'h5A5A_A5A5});
    serve(0, 5, waited);
    check("owner_kept", 64'(waited), 64'd0);

    // LSU then waits out a 10-cycle AR stall from the slave.
    serve(10, 0, waited);
    check("lsu_after_ifu_latency", 64'(waited), 64'd1);

    // Nothing left outstanding and the port is idle again.
    check("sb_drained", 64'(sb.size()), 64'd0);
    #1;
    check("final_idle", {58'd0, m_arvalid_o, m_rready_o, ifu_arready_o,
                         ifu_rvalid_o, lsu_arready_o, lsu_rvalid_o}, 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
